// File: rtl/sysarray_feed_ctrl.sv
// Operand sequencer for a 4x3 output-stationary systolic array: host-loaded A/B buffers, clear, skewed feed, done pulse.
// Optional SYSCTRL_PERF_EN adds run_cnt / run_num performance counters.
module sysarray_feed_ctrl #(
    parameter int DATA_SIZE = 8,
    parameter int KMAX      = 16,
    parameter int K_W       = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [1:0]           wr_row,
    input  logic [K_W-1:0]       wr_k,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 start,
    input  logic [K_W-1:0]       k_len,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_err,
    output logic                 arr_clr,
    output logic [DATA_SIZE-1:0] a1,
    output logic [DATA_SIZE-1:0] a2,
    output logic [DATA_SIZE-1:0] a3,
    output logic [DATA_SIZE-1:0] a4,
    output logic [DATA_SIZE-1:0] b1,
    output logic [DATA_SIZE-1:0] b2,
    output logic [DATA_SIZE-1:0] b3
`ifdef SYSCTRL_PERF_EN
    ,
    output logic [15:0]          run_cnt,
    output logic [7:0]           run_num
`endif
);

    localparam int T_W = K_W + 1;
    localparam int AW  = (KMAX > 1) ? $clog2(KMAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FEED, S_DONE} state_t;

    state_t               state_r;
    logic [K_W-1:0]       k_r;
    logic [T_W-1:0]       t_r;
    logic                 busy_r, done_r, wr_err_r, arr_clr_r;
    logic [DATA_SIZE-1:0] a_buf_r [4][KMAX];
    logic [DATA_SIZE-1:0] b_buf_r [3][KMAX];
    logic [DATA_SIZE-1:0] a_r [4];
    logic [DATA_SIZE-1:0] b_r [3];

    logic [DATA_SIZE-1:0] a_nxt_s [4];
    logic [DATA_SIZE-1:0] b_nxt_s [3];
    logic [T_W-1:0]       da_s [4];
    logic [T_W-1:0]       db_s [3];
    logic [T_W-1:0]       feed_t_s;
    logic [T_W-1:0]       t_last_s;
    logic                 load_s;
    logic                 wr_bad_s;
    logic                 wr_ok_s;
    logic [K_W-1:0]       k_sat_s;

    assign t_last_s = T_W'(k_r) + T_W'(4);
    assign k_sat_s  = (k_len > K_W'(KMAX)) ? K_W'(KMAX) : k_len;
    // Column 3 of B does not exist, so that address is an error rather than a silent drop.
    assign wr_bad_s = busy_r | (wr_k >= K_W'(KMAX)) | (wr_sel & (wr_row == 2'd3));
    assign wr_ok_s  = wr_en & ~wr_bad_s;

    // Operand values the output registers take at the next edge (skew by row/column index).
    always_comb begin
        feed_t_s = '0;
        load_s   = 1'b0;
        case (state_r)
            S_CLEAR: begin
                feed_t_s = '0;
                load_s   = (k_r != '0);
            end
            S_FEED: begin
                feed_t_s = t_r + T_W'(1);
                load_s   = (t_r != t_last_s);
            end
            default: begin
                feed_t_s = '0;
                load_s   = 1'b0;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            da_s[i]    = feed_t_s - T_W'(i);
            a_nxt_s[i] = '0;
            if (load_s && (feed_t_s >= T_W'(i)) && (da_s[i] < T_W'(k_r))) begin
                a_nxt_s[i] = a_buf_r[i][da_s[i][AW-1:0]];
            end else begin
                a_nxt_s[i] = '0;
            end
        end
        for (int j = 0; j < 3; j++) begin
            db_s[j]    = feed_t_s - T_W'(j);
            b_nxt_s[j] = '0;
            if (load_s && (feed_t_s >= T_W'(j)) && (db_s[j] < T_W'(k_r))) begin
                b_nxt_s[j] = b_buf_r[j][db_s[j][AW-1:0]];
            end else begin
                b_nxt_s[j] = '0;
            end
        end
    end

    // Operand buffers keep their contents across reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            if (wr_sel) begin
                b_buf_r[wr_row][wr_k[AW-1:0]] <= wr_data;
            end else begin
                a_buf_r[wr_row][wr_k[AW-1:0]] <= wr_data;
            end
        end
    end

    // Run sequencer with registered status and operand outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            k_r       <= '0;
            t_r       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wr_err_r  <= 1'b0;
            arr_clr_r <= 1'b1;
            for (int i = 0; i < 4; i++) a_r[i] <= '0;
            for (int j = 0; j < 3; j++) b_r[j] <= '0;
        end else begin
            wr_err_r  <= wr_en & wr_bad_s;
            done_r    <= 1'b0;
            arr_clr_r <= 1'b0;
            for (int i = 0; i < 4; i++) a_r[i] <= a_nxt_s[i];
            for (int j = 0; j < 3; j++) b_r[j] <= b_nxt_s[j];
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        k_r       <= k_sat_s;
                        busy_r    <= 1'b1;
                        arr_clr_r <= 1'b1;
                        state_r   <= S_CLEAR;
                    end else begin
                        state_r   <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    t_r <= '0;
                    if (k_r == '0) begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (t_r == t_last_s) begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        t_r     <= t_r + T_W'(1);
                    end
                end
                S_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SYSCTRL_PERF_EN
    logic [15:0] cyc_r;

    // Busy-cycle counter; its value in DONE is the inclusive run length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_r   <= 16'd0;
            run_cnt <= 16'd0;
            run_num <= 8'd0;
        end else begin
            if (state_r == S_IDLE && start) begin
                cyc_r <= 16'd1;
            end else if (busy_r && state_r != S_DONE) begin
                cyc_r <= cyc_r + 16'd1;
            end
            if (state_r == S_DONE) begin
                run_cnt <= cyc_r;
                run_num <= run_num + 8'd1;
            end
        end
    end
`endif

    assign busy    = busy_r;
    assign done    = done_r;
    assign wr_err  = wr_err_r;
    assign arr_clr = arr_clr_r;
    assign a1      = a_r[0];
    assign a2      = a_r[1];
    assign a3      = a_r[2];
    assign a4      = a_r[3];
    assign b1      = b_r[0];
    assign b2      = b_r[1];
    assign b3      = b_r[2];

endmodule

// File: tb/tb_sysarray_feed_ctrl.sv
// Bench for sysarray_feed_ctrl: behavioural 4x3 array model, shadow operand buffers, scoreboard of expected c values.
module tb_sysarray_feed_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
    logic [1:0] wr_row = 2'd0;
    logic [4:0] wr_k = 5'd0, k_len = 5'd0;
    logic [7:0] wr_data = 8'd0;
    logic       busy, done, wr_err, arr_clr;
    logic [7:0] a1, a2, a3, a4, b1, b2, b3;
`ifdef SYSCTRL_PERF_EN
    logic [15:0] run_cnt;
    logic [7:0]  run_num;
`endif

    int checks = 0;
    int errors = 0;
    int sa [4][16];
    int sb [3][16];
    int exp_q [$];
    int lat_q [$];

    sysarray_feed_ctrl #(.DATA_SIZE(8), .KMAX(16), .K_W(5)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_k(wr_k), .wr_data(wr_data), .start(start), .k_len(k_len),
        .busy(busy), .done(done), .wr_err(wr_err), .arr_clr(arr_clr),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .b1(b1), .b2(b2), .b3(b3)
`ifdef SYSCTRL_PERF_EN
        , .run_cnt(run_cnt), .run_num(run_num)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural output-stationary array driven by the controller outputs.
    logic [7:0]  arow [4];
    logic [7:0]  bcol [3];
    logic [7:0]  ma [4][3];
    logic [7:0]  mb [4][3];
    logic [16:0] mc [4][3];
    assign arow[0] = a1; assign arow[1] = a2; assign arow[2] = a3; assign arow[3] = a4;
    assign bcol[0] = b1; assign bcol[1] = b2; assign bcol[2] = b3;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                logic [7:0] ain, bin;
                ain = (j == 0) ? arow[i] : ma[i][j-1];
                bin = (i == 0) ? bcol[j] : mb[i-1][j];
                if (arr_clr) begin
                    ma[i][j] <= 8'd0; mb[i][j] <= 8'd0; mc[i][j] <= 17'd0;
                end else begin
                    ma[i][j] <= ain; mb[i][j] <= bin;
                    mc[i][j] <= mc[i][j] + 17'(ain) * 17'(bin);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int k);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++) begin
                int acc = 0;
                for (int kk = 0; kk < k; kk++) acc += sa[i][kk] * sb[j][kk];
                exp_q.push_back(acc % 131072);
            end
        lat_q.push_back((k == 0) ? 2 : k + 7);
    endtask

    task automatic do_write(input bit sel, input int row, input int kk, input int data, input bit exp_err);
        wr_en = 1'b1; wr_sel = sel; wr_row = row[1:0]; wr_k = kk[4:0]; wr_data = data[7:0];
        if (!exp_err) begin
            if (sel) sb[row][kk] = data; else sa[row][kk] = data;
        end
        tick;
        wr_en = 1'b0;
        checks++;
        if (wr_err !== exp_err) begin
            errors++;
            $display("FAIL wr_err sel=%0d row=%0d k=%0d: got %b want %b", sel, row, kk, wr_err, exp_err);
        end
    endtask

    task automatic start_run(input int kl, input bit hold, output int k);
        k = (kl > 16) ? 16 : kl;
        push_exp(k);
        start = 1'b1; k_len = kl[4:0];
        tick;
        start = hold;
        checks++;
        if (busy !== 1'b1 || arr_clr !== 1'b1) begin
            errors++;
            $display("FAIL accept: busy=%b arr_clr=%b want 1 1", busy, arr_clr);
        end
    endtask

    // Starts in the CLEAR cycle (cyc=1); ends in the cycle after DONE.
    task automatic wait_done(input int k, input int inj, input int abort_at);
        int cyc = 1;
        int bad = 0;
        int lat;
        while (cyc <= 60) begin
            if (cyc == abort_at) begin
                bit got = 0;
                reset = 1'b0;
                #1;
                checks++;
                if (busy !== 1'b0 || arr_clr !== 1'b1 || done !== 1'b0 || a1 !== 8'd0 || b1 !== 8'd0) begin
                    errors++;
                    $display("FAIL abort: busy=%b arr_clr=%b done=%b a1=%0d b1=%0d want 0 1 0 0 0", busy, arr_clr, done, a1, b1);
                end
                tick; tick;
                reset = 1'b1;
                repeat (30) begin
                    tick;
                    if (done === 1'b1) got = 1;
                end
                checks++;
                if (got) begin
                    errors++;
                    $display("FAIL abort_done: got a done pulse want none");
                end
                repeat (12) void'(exp_q.pop_front());
                void'(lat_q.pop_front());
                return;
            end
            for (int i = 0; i < 4; i++) begin
                int e = 0, d = cyc - 2 - i;
                logic [7:0] got_a;
                got_a = (i == 0) ? a1 : (i == 1) ? a2 : (i == 2) ? a3 : a4;
                if (cyc >= 2 && cyc <= k + 6 && d >= 0 && d < k) e = sa[i][d];
                if (got_a !== e[7:0]) bad++;
            end
            for (int j = 0; j < 3; j++) begin
                int e = 0, d = cyc - 2 - j;
                logic [7:0] got_b;
                got_b = (j == 0) ? b1 : (j == 1) ? b2 : b3;
                if (cyc >= 2 && cyc <= k + 6 && d >= 0 && d < k) e = sb[j][d];
                if (got_b !== e[7:0]) bad++;
            end
            if (cyc == inj) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_k = 5'd0; wr_data = 8'(sa[0][0] ^ 8'hFF);
            end
            if (done === 1'b1) break;
            tick;
            if (cyc == inj) begin
                wr_en = 1'b0;
                checks++;
                if (wr_err !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_wr_err: got %b want 1", wr_err);
                end
            end
            cyc++;
        end
        lat = lat_q.pop_front();
        checks++;
        if (done !== 1'b1 || cyc !== lat) begin
            errors++;
            $display("FAIL latency K=%0d: done=%b at cycle %0d want done=1 at %0d", k, done, cyc, lat);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stream K=%0d: %0d lane mismatches want 0", k, bad);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++) begin
                int e = exp_q.pop_front();
                checks++;
                if (mc[i][j] !== e[16:0]) begin
                    errors++;
                    $display("FAIL c%0d%0d K=%0d: got %0d want %0d", i + 1, j + 1, k, mc[i][j], e);
                end
            end
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_done: busy=%b done=%b want 0 0", busy, done);
        end
`ifdef SYSCTRL_PERF_EN
        checks++;
        if (run_cnt !== 16'(lat)) begin
            errors++;
            $display("FAIL run_cnt: got %0d want %0d", run_cnt, lat);
        end
`endif
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_err !== 1'b0 || arr_clr !== 1'b1 ||
            {a1, a2, a3, a4, b1, b2, b3} !== 56'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b wr_err=%b arr_clr=%b want 0 0 0 1, operands zero", busy, done, wr_err, arr_clr);
        end
        tick; tick;
        reset = 1'b1;
        tick;
        checks++;
        if (arr_clr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_state: arr_clr=%b busy=%b want 0 0", arr_clr, busy);
        end
    endtask

    task automatic test_k1;
        int k;
        for (int i = 0; i < 4; i++) do_write(1'b0, i, 0, i + 1, 1'b0);
        for (int j = 0; j < 3; j++) do_write(1'b1, j, 0, j + 1, 1'b0);
        start_run(1, 1'b0, k);
        wait_done(k, 0, 0);
    endtask

    task automatic test_k16;
        int k;
        for (int kk = 0; kk < 16; kk++) begin
            for (int i = 0; i < 4; i++) do_write(1'b0, i, kk, 255, 1'b0);
            for (int j = 0; j < 3; j++) do_write(1'b1, j, kk, 255, 1'b0);
        end
        start_run(16, 1'b0, k);
        wait_done(k, 0, 0);
        start_run(31, 1'b0, k);
        wait_done(k, 0, 0);
    endtask

    task automatic test_k0;
        int k;
        start_run(0, 1'b0, k);
        wait_done(k, 0, 0);
    endtask

    task automatic test_wr_err;
        int k;
        for (int kk = 0; kk < 4; kk++) begin
            for (int i = 0; i < 4; i++) do_write(1'b0, i, kk, int'($urandom_range(0, 255)), 1'b0);
            for (int j = 0; j < 3; j++) do_write(1'b1, j, kk, int'($urandom_range(0, 255)), 1'b0);
        end
        do_write(1'b1, 3, 0, 8'h5A, 1'b1);
        do_write(1'b0, 0, 16, 8'hA5, 1'b1);
        do_write(1'b1, 0, 17, 8'h3C, 1'b1);
        start_run(4, 1'b0, k);
        wait_done(k, 4, 0);
    endtask

    task automatic test_reset_mid;
        int k;
        start_run(4, 1'b0, k);
        wait_done(k, 0, 5);
        start_run(4, 1'b0, k);
        wait_done(k, 0, 0);
    endtask

    task automatic test_hold_start;
        int k;
        start_run(2, 1'b1, k);
        wait_done(k, 0, 0);
        push_exp(2);
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || arr_clr !== 1'b1) begin
            errors++;
            $display("FAIL hold_restart: busy=%b arr_clr=%b want 1 1", busy, arr_clr);
        end
        wait_done(2, 0, 0);
    endtask

    initial begin
        test_reset;
        test_k1;
        test_k16;
        test_k0;
        test_wr_err;
        test_reset_mid;
        test_hold_start;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
